// File: rtl/floo_pkg.sv
// Shared types for the floo router: fork FSM states and the route-mask type
// used by the route computation, reduction synchroniser and multicast fork.
package floo_pkg;

   localparam int unsigned NumRoutesDefault = 5;

   typedef logic [NumRoutesDefault-1:0] route_mask_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FORK  = 1'b1
   } fork_state_e;

endpackage

// File: rtl/floo_fork_tracker.sv
// Generic N-way eager fork tracker: remembers which selected outputs have
// already handshaked so each output drains independently.
module floo_fork_tracker #(
   parameter int unsigned N = 5
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         active_i,
   input  logic [N-1:0] mask_i,
   input  logic [N-1:0] ready_i,
   output logic [N-1:0] pending_o,
   output logic [N-1:0] sent_o,
   output logic         done_o
);

   logic [N-1:0] sent_r;

   assign pending_o = active_i ? (mask_i & ~sent_r) : {N{1'b0}};
   assign done_o    = active_i & ((pending_o & ~ready_i) == {N{1'b0}});
   assign sent_o    = sent_r;

   // Accumulate per-output handshakes; cleared once the whole fork completes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sent_r <= {N{1'b0}};
      end else if (done_o) begin
         sent_r <= {N{1'b0}};
      end else if (active_i) begin
         sent_r <= sent_r | (pending_o & ready_i);
      end else begin
         sent_r <= sent_r;
      end
   end

endmodule

// File: rtl/floo_multicast_fork_checker.sv
// Protocol properties of the multicast fork: non-empty held mask, sent set
// within the mask, and per-output valid/data stability until handshake.
module floo_multicast_fork_checker #(
   parameter int unsigned N = 5,
   parameter type flit_t = logic
) (
   input logic         clk_i,
   input logic         rst_i,
   input logic         in_fork_i,
   input logic [N-1:0] mask_q_i,
   input logic [N-1:0] sent_q_i,
   input logic [N-1:0] valid_o_i,
   input logic [N-1:0] ready_i,
   input flit_t        flit_q_i
);

   a_mask_nonzero: assert property (@(posedge clk_i) disable iff (rst_i)
      in_fork_i |-> (mask_q_i != {N{1'b0}}));

   a_sent_subset: assert property (@(posedge clk_i) disable iff (rst_i)
      (sent_q_i & ~mask_q_i) == {N{1'b0}});

   for (genvar r = 0; r < N; r++) begin : g_stable
      a_valid_stable: assert property (@(posedge clk_i) disable iff (rst_i)
         (valid_o_i[r] && !ready_i[r]) |=> (valid_o_i[r] && $stable(flit_q_i)));
   end

endmodule

// File: rtl/floo_multicast_fork.sv
// Replicates one multicast flit onto every output selected by its route mask,
// holding it until all selected outputs handshake; all-zero masks are dropped.
module floo_multicast_fork
   import floo_pkg::*;
#(
   parameter int unsigned NumRoutes = NumRoutesDefault,
   parameter type flit_t = logic,
   parameter type id_t = logic,
   parameter int unsigned CntWidth = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  flit_t                 data_i,
   input  logic [NumRoutes-1:0]  route_mask_i,
   output logic [NumRoutes-1:0]  valid_o,
   input  logic [NumRoutes-1:0]  ready_i,
   output flit_t [NumRoutes-1:0] data_o,
   output logic                  drop_o,
   output logic [CntWidth-1:0]   drop_cnt_o
);

   if (CntWidth < $bits(id_t)) begin : g_bad_cnt_width
      $error("floo_multicast_fork: CntWidth narrower than id_t");
   end

   fork_state_e          state_r;
   flit_t                flit_r;
   logic [NumRoutes-1:0] mask_r;
   logic                 drop_r;
   logic [CntWidth-1:0]  cnt_r;

   logic [NumRoutes-1:0] pending_s;
   logic [NumRoutes-1:0] sent_s;
   logic                 done_s;
   logic                 in_fork_s;
   logic                 accept_s;
   logic                 mask_zero_s;

   assign in_fork_s   = (state_r == FORK);
   assign mask_zero_s = (route_mask_i == {NumRoutes{1'b0}});
   // ready_o depends on ready_i through done_s so back-to-back flits flow at full rate.
   assign ready_o     = !in_fork_s || done_s;
   assign accept_s    = valid_i && ready_o;

   floo_fork_tracker #(
      .N (NumRoutes)
   ) i_tracker (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .active_i  (in_fork_s),
      .mask_i    (mask_r),
      .ready_i   (ready_i),
      .pending_o (pending_s),
      .sent_o    (sent_s),
      .done_o    (done_s)
   );

   // pending_s is built from registers only, so valid_o has no path from ready_i.
   assign valid_o    = pending_s;
   assign data_o     = {NumRoutes{flit_r}};
   assign drop_o     = drop_r;
   assign drop_cnt_o = cnt_r;

   // Holding register, fork state and drop accounting.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r <= EMPTY;
         flit_r  <= flit_t'(0);
         mask_r  <= {NumRoutes{1'b0}};
         drop_r  <= 1'b0;
         cnt_r   <= {CntWidth{1'b0}};
      end else begin
         drop_r <= 1'b0;
         if (accept_s && !mask_zero_s) begin
            state_r <= FORK;
            flit_r  <= data_i;
            mask_r  <= route_mask_i;
         end else if (done_s) begin
            state_r <= EMPTY;
         end else begin
            state_r <= state_r;
         end
         if (accept_s && mask_zero_s) begin
            drop_r <= 1'b1;
            if (cnt_r != {CntWidth{1'b1}}) begin
               cnt_r <= cnt_r + CntWidth'(1);
            end else begin
               cnt_r <= cnt_r;
            end
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   floo_multicast_fork_checker #(
      .N      (NumRoutes),
      .flit_t (flit_t)
   ) i_checker (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .in_fork_i (in_fork_s),
      .mask_q_i  (mask_r),
      .sent_q_i  (sent_s),
      .valid_o_i (valid_o),
      .ready_i   (ready_i),
      .flit_q_i  (flit_r)
   );

endmodule

// File: tb/tb_floo_multicast_fork.sv
// Randomised and directed bench for floo_multicast_fork, checked against a
// set-based transaction model with per-output in-order scoreboards.
module tb_floo_multicast_fork;

   localparam int NR = 5;

   logic             clk = 1'b0;
   logic             rst_i = 1'b1;
   logic             valid_i = 1'b0;
   logic [31:0]      data_i = 32'd0;
   logic [NR-1:0]    route_mask_i = 5'b00000;
   logic [NR-1:0]    ready_i = 5'b00000;
   logic             ready_o, ready_o_sm;
   logic [NR-1:0]    valid_o, valid_o_sm;
   logic [NR-1:0][31:0] data_o, data_o_sm;
   logic             drop_o, drop_o_sm;
   logic [15:0]      drop_cnt_o;
   logic [3:0]       drop_cnt_sm;

   always #5 clk = ~clk;

   floo_multicast_fork #(.NumRoutes(NR), .flit_t(logic [31:0]), .CntWidth(16)) dut (
      .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
      .route_mask_i(route_mask_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
      .drop_o(drop_o), .drop_cnt_o(drop_cnt_o));

   // Narrow-counter copy, used to reach counter saturation quickly.
   floo_multicast_fork #(.NumRoutes(NR), .flit_t(logic [31:0]), .CntWidth(4)) dut_sm (
      .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o_sm), .data_i(data_i),
      .route_mask_i(route_mask_i), .valid_o(valid_o_sm), .ready_i(ready_i), .data_o(data_o_sm),
      .drop_o(drop_o_sm), .drop_cnt_o(drop_cnt_sm));

   int check_cnt = 0;
   int err_cnt = 0;

   // Model: a held flit plus the set of outputs still owed a copy.
   logic          m_busy;
   logic [NR-1:0] m_rem;
   logic [31:0]   m_flit;
   logic          m_drop;
   int            m_drops;
   logic [31:0]   sb_q [NR][$];

   logic [NR-1:0] last_valid;
   logic          last_ready;
   logic          last_acc;
   logic [15:0]   last_cnt;
   logic [3:0]    last_cnt_sm;

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      check_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0; m_rem = 5'b00000; m_flit = 32'd0; m_drop = 1'b0; m_drops = 0;
      for (int r = 0; r < NR; r++) sb_q[r].delete();
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_i = 1'b1; valid_i = 1'b0; ready_i = 5'b00000;
      @(posedge clk);
      @(negedge clk);
      rst_i = 1'b0;
      model_reset();
      #1;
      check_value("rst_valid", 64'(valid_o), 64'd0);
      check_value("rst_ready", 64'(ready_o), 64'd1);
      check_value("rst_cnt", 64'(drop_cnt_o), 64'd0);
      check_value("rst_drop", 64'(drop_o), 64'd0);
   endtask

   // One clock: drive, compare against the model, then advance the model.
   task automatic cycle(input logic v, input logic [31:0] d, input logic [NR-1:0] m,
                        input logic [NR-1:0] rdy);
      logic exp_ready;
      logic acc;
      @(negedge clk);
      valid_i = v; data_i = d; route_mask_i = m; ready_i = rdy;
      #1;
      exp_ready = !m_busy || ((m_rem & ~rdy) == 5'b00000);
      check_value("valid_o", 64'(valid_o), 64'(m_busy ? m_rem : 5'b00000));
      check_value("ready_o", 64'(ready_o), 64'(exp_ready));
      check_value("drop_o", 64'(drop_o), 64'(m_drop));
      check_value("drop_cnt", 64'(drop_cnt_o), 64'((m_drops > 65535) ? 65535 : m_drops));
      check_value("drop_cnt_sm", 64'(drop_cnt_sm), 64'((m_drops > 15) ? 15 : m_drops));
      for (int r = 0; r < NR; r++) begin
         if (valid_o[r]) check_value("data_o", 64'(data_o[r]), 64'(m_flit));
         if (valid_o[r] && rdy[r]) begin
            check_value("sb_nonempty", 64'(sb_q[r].size() != 0), 64'd1);
            if (sb_q[r].size() != 0) check_value("sb_order", 64'(data_o[r]), 64'(sb_q[r].pop_front()));
         end
      end
      last_valid = valid_o; last_ready = ready_o;
      last_cnt = drop_cnt_o; last_cnt_sm = drop_cnt_sm;
      acc = v && exp_ready;
      last_acc = acc;
      @(posedge clk);
      if (m_busy) begin
         m_rem = m_rem & ~rdy;
         if (m_rem == 5'b00000) m_busy = 1'b0;
      end
      m_drop = 1'b0;
      if (acc) begin
         if (m != 5'b00000) begin
            m_busy = 1'b1; m_rem = m; m_flit = d;
            for (int r = 0; r < NR; r++) if (m[r]) sb_q[r].push_back(d);
         end else begin
            m_drop = 1'b1; m_drops++;
         end
      end
   endtask

   initial begin
      int n_acc;
      int cyc;
      logic [NR-1:0] rm;
      logic [NR-1:0] rr;
      model_reset();
      apply_reset();

      // Unicast, back-to-back at full throughput.
      cycle(1'b1, 32'hAAAA0001, 5'b00100, 5'b11111);
      check_value("uni_rdy0", 64'(last_ready), 64'd1);
      cycle(1'b1, 32'hBBBB0002, 5'b00100, 5'b11111);
      check_value("uni_v1", 64'(last_valid), 64'(5'b00100));
      check_value("uni_acc1", 64'(last_acc), 64'd1);
      cycle(1'b0, 32'd0, 5'b00000, 5'b11111);
      check_value("uni_v2", 64'(last_valid), 64'(5'b00100));
      cycle(1'b0, 32'd0, 5'b00000, 5'b11111);

      // Multicast with output 1 stalled for three cycles.
      cycle(1'b1, 32'hCCCC0003, 5'b10110, 5'b11111);
      for (int i = 1; i <= 5; i++) begin
         cycle(1'b0, 32'd0, 5'b00000, (i <= 3) ? 5'b11101 : 5'b11111);
         check_value("mc_ready", 64'(last_ready), 64'(i >= 4));
         if (i >= 2 && i <= 4) check_value("mc_valid", 64'(last_valid), 64'(5'b00010));
      end
      check_value("mc_empty", 64'(last_valid), 64'd0);

      // Staggered readies, one output per cycle.
      cycle(1'b1, 32'hDDDD0004, 5'b11111, 5'b00000);
      for (int i = 0; i < NR; i++) begin
         rr = 5'b00001 << i;
         cycle(1'b0, 32'd0, 5'b00000, rr);
         check_value("stag_ready", 64'(last_ready), 64'(i == NR - 1));
      end

      // Zero masks are dropped and counted.
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'hEEEE0000 + i, 5'b00000, 5'b11111);
      cycle(1'b0, 32'd0, 5'b00000, 5'b11111);
      check_value("drop_cnt3", 64'(last_cnt), 64'd3);
      check_value("drop_nov", 64'(last_valid), 64'd0);
      for (int i = 0; i < 20; i++) cycle(1'b1, 32'd0, 5'b00000, 5'b00000);
      cycle(1'b0, 32'd0, 5'b00000, 5'b11111);
      check_value("drop_sat", 64'(last_cnt_sm), 64'hF);
      check_value("drop_cnt23", 64'(last_cnt), 64'd23);

      // Reset in the middle of a fork discards the held flit.
      cycle(1'b1, 32'h12340005, 5'b00011, 5'b00000);
      cycle(1'b0, 32'd0, 5'b00000, 5'b00000);
      cycle(1'b0, 32'd0, 5'b00000, 5'b00000);
      apply_reset();
      cycle(1'b1, 32'h56780006, 5'b01001, 5'b11111);
      cycle(1'b0, 32'd0, 5'b00000, 5'b11111);
      check_value("post_rst_v", 64'(last_valid), 64'(5'b01001));

      // Random traffic with random back-pressure.
      n_acc = 0;
      cyc = 0;
      while (n_acc < 10000 && cyc < 60000) begin
         rm = ($urandom_range(0, 9) == 0) ? 5'b00000 : NR'($urandom_range(1, 31));
         for (int r = 0; r < NR; r++) rr[r] = ($urandom_range(0, 3) != 0);
         cycle($urandom_range(0, 3) != 0, $urandom, rm, rr);
         if (last_acc && rm != 5'b00000) n_acc++;
         cyc++;
      end
      check_value("rand_budget", 64'(n_acc >= 10000), 64'd1);
      for (int i = 0; i < 10; i++) cycle(1'b0, 32'd0, 5'b00000, 5'b11111);
      for (int r = 0; r < NR; r++) check_value("sb_drained", 64'(sb_q[r].size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/floo_multicast_fork.md
Name: floo_multicast_fork

Overview:
- Output-side counterpart of the reduction synchroniser: replicates one incoming multicast flit onto every output route selected by a route mask.
- Holds the flit until each selected output has handshaked, and tracks per-output completion so outputs drain independently.
- Sits in the router after route computation; the mask comes from floo_route_xymask in output mode (Mode 1).

Parameters:
- NumRoutes, 5, number of output routes.
- flit_t, logic, flit type; must contain hdr.
- id_t, logic, node id type; used only for the drop-count width check.
- CntWidth, 16, width of the dropped-flit counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- valid_i  in  1  input flit valid.
- ready_o  out  1  input flit accepted.
- data_i  in  flit_t  input flit.
- route_mask_i  in  NumRoutes  selected output routes for data_i; sampled with the flit.
- valid_o  out  NumRoutes  per-output valid.
- ready_i  in  NumRoutes  per-output ready.
- data_o  out  NumRoutes x flit_t  per-output flit copy.
- drop_o  out  1  one-cycle pulse when a flit with an all-zero mask is consumed.
- drop_cnt_o  out  CntWidth  saturating count of dropped flits.

Behaviour:
- Storage: one-entry holding register (flit_q, mask_q) plus a sent_q[NumRoutes] register.
- FSM states:
  - EMPTY: holding register invalid.
  - FORK: flit held; pending = mask_q & ~sent_q.
- Outputs:
  - In FORK: valid_o[r] = pending[r]; data_o[r] = flit_q for all r (data is don't-care when valid is low).
  - In EMPTY: valid_o = 0.
- done = FORK and (pending & ~ready_i) == 0, i.e. every still-pending output handshakes this cycle.
- ready_o = EMPTY or done. This allows back-to-back flits at full throughput when all outputs are ready.
- Accept (valid_i and ready_o):
  - route_mask_i != 0: load flit_q and mask_q, clear sent_q, enter FORK. Latency is 1: the flit appears on valid_o the cycle after acceptance.
  - route_mask_i == 0: do not load; pulse drop_o; increment drop_cnt_o, saturating at all-ones. State is EMPTY next, or stays EMPTY.
- In FORK without done: sent_q |= pending & ready_i.
- Done without a new accept: return to EMPTY and clear sent_q.
- Done with a simultaneous accept: the new flit overwrites the holding register (FORK -> FORK).
- Stability: once valid_o[r] is asserted, it stays high with data_o[r] unchanged until ready_i[r]. There is no revocation.
- Readiness independence: an output whose mask bit is 0 never sees valid_o, and its ready_i is ignored. ready_i may depend on valid_o; valid_o never depends on ready_i (no combinational path ready_i -> valid_o).
- ready_o depends combinationally on ready_i. This is documented; the upstream must not create a loop.
- Reset, applied synchronously, including mid-fork:
  - state = EMPTY; flit_q and mask_q = 0; sent_q = 0.
  - drop_cnt_o = 0; drop_o = 0; valid_o = 0; ready_o = 1 after reset.
  - A partially forked flit is discarded.
- Assertions:
  - mask_q != 0 in FORK.
  - valid_o stable until handshake.
  - sent_q is a subset of mask_q.

Decomposition:
- floo_pkg gets:
  - fork_state_e (EMPTY, FORK).
  - A route-mask typedef, logic [NumRoutes-1:0], reused by floo_route_xymask Mode 1 and the reduction synchroniser.
- Natural sub-module: floo_fork_tracker, holding sent_q/pending/done for a generic N-way eager fork. The top adds the holding register, drop logic and counter.

Test Plan (NumRoutes=5):
- Unicast, mask=5'b00100, ready_i=all-ones, flit A at cycle 0:
  - valid_o=5'b00100 at cycle 1 with data A.
  - ready_o=1 throughout.
  - Next flit B accepted at cycle 1 and shown at cycle 2.
- Multicast, mask=5'b10110, ready_i[1]=0 for 3 cycles, others ready:
  - Cycle 1: outputs 2 and 4 handshake; valid_o becomes 5'b00010.
  - Output 1 fires at cycle 4.
  - ready_o stays 0 until cycle 4; state returns to EMPTY at cycle 5.
- Staggered readies on mask=5'b11111 (one ready per cycle, r=0..4):
  - Each output fires exactly once; data is identical on all.
  - ready_o=1 only in the cycle output 4 fires.
- Zero mask with valid_i=1 for 3 consecutive cycles:
  - drop_o high 3 cycles; drop_cnt_o=3; valid_o stays 0.
  - Saturation: preload to 0xFFFF, one more drop leaves 0xFFFF.
- Reset mid-fork: mask=5'b00011, ready_i=0, assert rst_i at cycle 3:
  - Cycle 4: valid_o=0, ready_o=1, drop_cnt_o=0.
  - A new flit after reset forks normally.
- Random back-pressure, 10k flits with random masks:
  - Scoreboard confirms each output receives exactly the flits whose mask bit is set, in order.
  - No duplicates; stability assertion never fires.
